// File: rtl/uart_tx_streamer_pkg.sv
// Shared image/transfer parameters and FSM state encoding for the UART image streamer.
package uart_tx_streamer_pkg;
  localparam int ADDR_W_DEF     = 18;
  localparam int DATA_W_DEF     = 8;
  localparam int START_ADDR_DEF = 0;
  localparam int IMG_BYTES_DEF  = 16384;
  localparam int MEM_LAT_DEF    = 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_HI, WAIT_LO, DONE
  } state_e;

  // Byte counter must hold 0..IMG_BYTES.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/uart_tx_streamer_if.sv
// Memory-read / UART-TX handshake bundle between the streamer and its surroundings.
interface uart_tx_streamer_if
  import uart_tx_streamer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              tx_start;
  logic [DATA_W-1:0] mem_Dout;
  logic              tx_busy;
  logic [ADDR_W-1:0] uart_addrs;
  logic [DATA_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_end;

  modport master (
    input  tx_start, mem_Dout, tx_busy,
    output uart_addrs, tx_data, tx_send, tx_end
  );
  modport slave (
    output tx_start, mem_Dout, tx_busy,
    input  uart_addrs, tx_data, tx_send, tx_end
  );
endinterface

// File: rtl/uart_tx_streamer.sv
// Streams IMG_BYTES bytes from shared memory to the UART transmitter after a tx_start rising edge.
module uart_tx_streamer
  import uart_tx_streamer_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF,
  parameter int IMG_BYTES  = IMG_BYTES_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF
) (
  input logic                clock_100,
  input logic                rst_n,
  uart_tx_streamer_if.master bus
);
  localparam int                CNT_W    = cnt_width(IMG_BYTES);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(START_ADDR);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(IMG_BYTES - 1);
  localparam logic [1:0]        LAT_LAST = 2'(MEM_LAT - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lat;
  logic              tx_start_q;
  logic              start_p;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] uart_addrs;
  logic [DATA_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_end;

  assign start_p   = bus.tx_start & ~tx_start_q;
  assign next_addr = BASE + ADDR_W'(cnt) + ADDR_W'(1);

  assign bus.uart_addrs = uart_addrs;
  assign bus.tx_data    = tx_data;
  assign bus.tx_send    = tx_send;
  assign bus.tx_end     = tx_end;

  always_ff @(posedge clock_100 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lat        <= '0;
      tx_start_q <= 1'b0;
      uart_addrs <= BASE;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      tx_end     <= 1'b0;
    end else begin
      tx_start_q <= bus.tx_start;
      tx_send    <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt        <= '0;
          lat        <= '0;
          uart_addrs <= BASE;
          if (start_p) state <= FETCH;
        end
        // Address has been stable since entry; count out the memory latency,
        // then hold the fetched byte until the UART is free.
        FETCH: begin
          if (lat != LAT_LAST) begin
            lat <= lat + 2'd1;
          end else if (!bus.tx_busy) begin
            tx_data <= bus.mem_Dout;
            tx_send <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD:    state <= WAIT_HI;
        WAIT_HI: if (bus.tx_busy) state <= WAIT_LO;
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            lat <= '0;
            if (cnt == LAST) begin
              tx_end <= 1'b1;
              state  <= DONE;
            end else begin
              cnt        <= cnt + CNT_W'(1);
              uart_addrs <= next_addr;
              state      <= FETCH;
            end
          end
        end
        // Sticky until reset; later start edges are ignored.
        DONE:    tx_end <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_streamer.sv
// Scoreboard bench: three streamer configurations, each with its own memory and UART model.
module tb_uart_tx_streamer;
  localparam int NI = 3;
  // Instance 0: 4 bytes, lat 1. Instance 1: 4 bytes, lat 3. Instance 2: 1 byte at 3FFFF.
  localparam logic [NI-1:0][31:0] IB = {32'd1, 32'd4, 32'd4};
  localparam logic [NI-1:0][31:0] ML = {32'd1, 32'd3, 32'd1};
  localparam logic [NI-1:0][31:0] SA = {32'h3FFFF, 32'd0, 32'd0};

  typedef struct {
    int         inst;
    logic [17:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [NI];
  logic        hold    [NI];
  int          start_cyc [NI];
  logic [17:0] addr_w  [NI];
  logic [7:0]  data_w  [NI];
  logic        send_w  [NI];
  logic        end_w   [NI];
  int          cyc = 0;
  int          sends = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    uart_tx_streamer_if #(.ADDR_W(18), .DATA_W(8)) bus ();

    uart_tx_streamer #(
      .ADDR_W(18), .DATA_W(8), .START_ADDR(int'(SA[g])),
      .IMG_BYTES(int'(IB[g])), .MEM_LAT(int'(ML[g]))
    ) dut (
      .clock_100(clk),
      .rst_n    (rst_n),
      .bus      (bus.master)
    );

    // Memory: contents A0+addr[7:0], read latency ML cycles.
    logic [7:0] mem_comb;
    logic [7:0] pipe0 = '0;
    logic [7:0] pipe1 = '0;
    assign mem_comb = 8'hA0 + bus.uart_addrs[7:0];
    always @(posedge clk) begin
      pipe0 <= mem_comb;
      pipe1 <= pipe0;
    end
    assign bus.mem_Dout = (ML[g] == 1) ? mem_comb : ((ML[g] == 2) ? pipe0 : pipe1);

    // UART: busy for 10 cycles after accepting a byte.
    int bcnt = 0;
    always @(posedge clk) begin
      if (bcnt != 0) bcnt <= bcnt - 1;
      else if (bus.tx_send) bcnt <= 10;
    end
    assign bus.tx_busy  = (bcnt != 0) | hold[g];
    assign bus.tx_start = start_v[g];

    assign addr_w[g] = bus.uart_addrs;
    assign data_w[g] = bus.tx_data;
    assign send_w[g] = bus.tx_send;
    assign end_w[g]  = bus.tx_end;

    logic prev_busy = 1'b0;
    logic prev_end  = 1'b0;
    int   last_fall = -100;
    int   seen_start = -1;
    exp_t e;

    always @(negedge clk) begin
      if (rst_n) begin
        if (prev_busy && !bus.tx_busy) last_fall <= cyc;
        if (bus.tx_end && !prev_end)
          check($sformatf("end_lat%0d", g), 32'(cyc - last_fall), 32'd1);
        if (bus.tx_send) begin
          sends++;
          check($sformatf("busy_at_send%0d", g), {31'd0, bus.tx_busy}, 32'd0);
          if (start_cyc[g] >= 0 && start_cyc[g] != seen_start) begin
            check($sformatf("first_lat%0d", g), 32'(cyc - start_cyc[g]), ML[g] + 1);
            seen_start <= start_cyc[g];
          end
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_send%0d", g), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("send_inst%0d", g), 32'(g), 32'(e.inst));
            check($sformatf("send_addr%0d", g), {14'd0, bus.uart_addrs}, {14'd0, e.addr});
            check($sformatf("send_data%0d", g), {24'd0, bus.tx_data}, {24'd0, e.data});
          end
        end
      end
      prev_busy <= bus.tx_busy;
      prev_end  <= bus.tx_end;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [17:0] a, input logic [7:0] d);
    exp_t x;
    x.inst = g; x.addr = a; x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic push_four(input int g);
    push(g, 18'd0, 8'hA0);
    push(g, 18'd1, 8'hA1);
    push(g, 18'd2, 8'hA2);
    push(g, 18'd3, 8'hA3);
  endtask

  task automatic wait_sends(input int target, input int budget);
    while (sends < target && budget > 0) begin tick(1); budget--; end
    check("send_timeout", {31'd0, sends >= target}, 32'd1);
  endtask

  task automatic wait_end(input int g, input int budget);
    while (end_w[g] !== 1'b1 && budget > 0) begin tick(1); budget--; end
    check($sformatf("end_timeout%0d", g), {31'd0, end_w[g]}, 32'd1);
  endtask

  task automatic check_reset(input int g);
    check($sformatf("rst_addr%0d", g), {14'd0, addr_w[g]}, SA[g]);
    check($sformatf("rst_data%0d", g), {24'd0, data_w[g]}, 32'd0);
    check($sformatf("rst_send%0d", g), {31'd0, send_w[g]}, 32'd0);
    check($sformatf("rst_end%0d", g), {31'd0, end_w[g]}, 32'd0);
  endtask

  int n0;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; hold[i] = 1'b0; start_cyc[i] = -1;
    end
    tick(3);
    for (int i = 0; i < NI; i++) check_reset(i);
    rst_n = 1'b1;
    tick(1000);
    check("idle_sends", 32'(sends), 32'd0);
    check("idle_end0", {31'd0, end_w[0]}, 32'd0);

    // Four bytes; tx_start toggles during byte 2 and must be ignored.
    push_four(0);
    n0 = sends;
    start_cyc[0] = cyc;
    start_v[0] = 1'b1;
    wait_sends(n0 + 2, 300);
    start_v[0] = 1'b0;
    tick(3);
    start_v[0] = 1'b1;
    wait_end(0, 500);
    check("sends_a", 32'(sends - n0), 32'd4);
    check("q_empty_a", 32'(exp_q.size()), 32'd0);
    check("addr_a_final", {14'd0, addr_w[0]}, 32'd3);
    // Start pulse after completion: no further sends, tx_end stays high.
    n0 = sends;
    tick(5);
    start_v[0] = 1'b0;
    tick(3);
    start_v[0] = 1'b1;
    tick(100);
    check("post_done_sends", 32'(sends - n0), 32'd0);
    check("post_done_end", {31'd0, end_w[0]}, 32'd1);

    // UART busy at start with MEM_LAT 3: stall, then send A0 first.
    push_four(1);
    n0 = sends;
    hold[1] = 1'b1;
    start_v[1] = 1'b1;
    tick(50);
    check("stall_sends", 32'(sends - n0), 32'd0);
    hold[1] = 1'b0;
    wait_end(1, 500);
    check("sends_b", 32'(sends - n0), 32'd4);
    check("q_empty_b", 32'(exp_q.size()), 32'd0);

    // Single byte at the top of the address space.
    push(2, 18'h3FFFF, 8'h9F);
    n0 = sends;
    start_cyc[2] = cyc;
    start_v[2] = 1'b1;
    wait_end(2, 200);
    tick(20);
    check("sends_c", 32'(sends - n0), 32'd1);
    check("addr_c_nowrap", {14'd0, addr_w[2]}, 32'h3FFFF);
    check("q_empty_c", 32'(exp_q.size()), 32'd0);

    // Abort mid-transfer with reset, then restart from START_ADDR.
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    push_four(0);
    n0 = sends;
    start_cyc[0] = cyc;
    start_v[0] = 1'b1;
    wait_sends(n0 + 2, 300);
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(0);
    check("abort_sends", 32'(sends - n0), 32'd2);
    exp_q.delete();
    start_v[0] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    push_four(0);
    n0 = sends;
    start_cyc[0] = cyc;
    start_v[0] = 1'b1;
    wait_end(0, 500);
    tick(5);
    check("sends_restart", 32'(sends - n0), 32'd4);
    check("q_empty_restart", 32'(exp_q.size()), 32'd0);
    check("end_restart", {31'd0, end_w[0]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
